spm_bank_arbiter: RTL and testbench

Round-robin arbiter that shares one scratchpad SRAM bank port among `NREQ` requesters (e.g. systolic array feeder, DMA, host CSR path). It selects one requester per cycle and drives the bank's ren/wen/addr/wdata. It tracks the in-flight read so that the bank's one-cycle-late rvalid/rdata reach the requester that issued it. Optional locked bursts keep ownership across back-to-back accesses, with a hard cap so other requesters cannot starve.

---
 rtl/spm_bank_arbiter_if.sv | 39 +++
 rtl/spm_bank_arbiter.sv | 146 ++++++++++++++
 tb/tb_spm_bank_arbiter.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/spm_bank_arbiter_if.sv
// Bus bundle between the scratchpad bank arbiter, its requesters and the SRAM bank.
// The arbiter connects through the slave modport; the environment uses master.
interface spm_bank_arbiter_if #(
  parameter int NREQ = 2,
  parameter int AW   = 9,
  parameter int DW   = 32
);
  logic [NREQ-1:0]    req_ren;
  logic [NREQ-1:0]    req_wen;
  logic [NREQ-1:0]    req_lock;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_wdata;
  logic [NREQ-1:0]    req_gnt;
  logic [NREQ-1:0]    req_rvalid;
  logic [DW-1:0]      req_rdata;
  logic               bank_ren;
  logic               bank_wen;
  logic [AW-1:0]      bank_addr;
  logic [DW-1:0]      bank_wdata;
  logic [DW-1:0]      bank_rdata;
  logic               bank_rvalid;
  logic               err_orphan;

  modport master (
    output req_ren, req_wen, req_lock, req_addr, req_wdata,
    input  req_gnt, req_rvalid, req_rdata,
    input  bank_ren, bank_wen, bank_addr, bank_wdata,
    output bank_rdata, bank_rvalid,
    input  err_orphan
  );

  modport slave (
    input  req_ren, req_wen, req_lock, req_addr, req_wdata,
    output req_gnt, req_rvalid, req_rdata,
    output bank_ren, bank_wen, bank_addr, bank_wdata,
    input  bank_rdata, bank_rvalid,
    output err_orphan
  );
endinterface

// File: rtl/spm_bank_arbiter.sv
// Round-robin arbiter sharing one scratchpad SRAM bank port among NREQ requesters.
// Grants are combinational; a registered read tag routes the bank's one-cycle-late
// response back to the requester that issued the read. Locked bursts keep
// ownership up to MAX_BURST consecutive grants while others are waiting.
module spm_bank_arbiter #(
  parameter int NREQ      = 2,
  parameter int AW        = 9,
  parameter int DW        = 32,
  parameter int MAX_BURST = 16
) (
  input logic             clk,
  input logic             rst_n,
  spm_bank_arbiter_if.slave bus
);
  localparam int          IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [7:0]  CAP = 8'(MAX_BURST);

  // One-hot decode of a requester index.
  function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] idx);
    logic [NREQ-1:0] v;
    for (int i = 0; i < NREQ; i++) begin
      v[i] = (idx == IW'(i));
    end
    return v;
  endfunction

  logic [IW-1:0]   last_r;
  logic [IW-1:0]   owner_r;
  logic            owner_locked_r;
  logic [7:0]      burst_cnt_r;
  logic            tag_valid_r;
  logic [IW-1:0]   tag_idx_r;
  logic [AW-1:0]   addr_hold_r;
  logic [DW-1:0]   wdata_hold_r;

  logic [NREQ-1:0] req_s;
  logic            rr_found_s;
  logic [IW-1:0]   rr_idx_s;
  logic            others_s;
  logic            cap_hit_s;
  logic            lock_win_s;
  logic [IW-1:0]   gnt_idx_s;
  logic [NREQ-1:0] gnt_oh_s;
  logic            gnt_any_s;
  logic            gnt_rd_s;
  logic            gnt_wr_s;
  logic            gnt_lock_s;
  logic [AW-1:0]   gnt_addr_s;
  logic [DW-1:0]   gnt_wdata_s;
  logic            locked_nxt_s;
  logic [IW-1:0]   owner_nxt_s;
  logic [7:0]      cnt_nxt_s;

  assign req_s = bus.req_ren | bus.req_wen;

  // Round-robin search: first requester after the most recent grant wins.
  always_comb begin
    rr_found_s = 1'b0;
    rr_idx_s   = last_r;
    for (int off = 1; off <= NREQ; off++) begin
      rr_idx_s   = (!rr_found_s && (|(req_s & onehot(IW'((int'(last_r) + off) % NREQ)))))
                   ? IW'((int'(last_r) + off) % NREQ) : rr_idx_s;
      rr_found_s = rr_found_s || (|(req_s & onehot(IW'((int'(last_r) + off) % NREQ))));
    end
  end

  // Lock override, burst cap and selection of the granted requester's fields.
  always_comb begin
    others_s    = |(req_s & ~onehot(owner_r));
    cap_hit_s   = (burst_cnt_r == CAP) && others_s;
    lock_win_s  = owner_locked_r && (|(req_s & onehot(owner_r))) && !cap_hit_s;
    gnt_idx_s   = lock_win_s ? owner_r : rr_idx_s;
    gnt_any_s   = rst_n && (lock_win_s || rr_found_s);
    gnt_oh_s    = gnt_any_s ? onehot(gnt_idx_s) : '0;
    gnt_wr_s    = |(gnt_oh_s & bus.req_wen);
    gnt_rd_s    = (|(gnt_oh_s & bus.req_ren)) && !gnt_wr_s;
    gnt_lock_s  = |(gnt_oh_s & bus.req_lock);
    gnt_addr_s  = addr_hold_r;
    gnt_wdata_s = wdata_hold_r;
    for (int i = 0; i < NREQ; i++) begin
      gnt_addr_s  = (gnt_idx_s == IW'(i)) ? bus.req_addr[i*AW +: AW]  : gnt_addr_s;
      gnt_wdata_s = (gnt_idx_s == IW'(i)) ? bus.req_wdata[i*DW +: DW] : gnt_wdata_s;
    end
  end

  // Next lock/burst state: continue, start a new owner, or release.
  always_comb begin
    locked_nxt_s = 1'b0;
    owner_nxt_s  = owner_r;
    cnt_nxt_s    = 8'd0;
    if (gnt_any_s && gnt_lock_s) begin
      locked_nxt_s = 1'b1;
      owner_nxt_s  = gnt_idx_s;
      if (lock_win_s) begin
        cnt_nxt_s = (burst_cnt_r >= CAP) ? CAP : (burst_cnt_r + 8'd1);
      end else begin
        cnt_nxt_s = 8'd1;
      end
    end else begin
      locked_nxt_s = 1'b0;
      owner_nxt_s  = owner_r;
      cnt_nxt_s    = 8'd0;
    end
  end

  // Requester and bank outputs; response routing is gated off during reset.
  always_comb begin
    bus.req_gnt    = gnt_oh_s;
    bus.bank_ren   = gnt_rd_s;
    bus.bank_wen   = gnt_wr_s;
    bus.bank_addr  = gnt_any_s ? gnt_addr_s  : addr_hold_r;
    bus.bank_wdata = gnt_any_s ? gnt_wdata_s : wdata_hold_r;
    bus.req_rdata  = bus.bank_rdata;
    bus.err_orphan = rst_n && bus.bank_rvalid && !tag_valid_r;
    if (rst_n && bus.bank_rvalid && tag_valid_r) begin
      bus.req_rvalid = onehot(tag_idx_r);
    end else begin
      bus.req_rvalid = '0;
    end
  end

  // State registers: round-robin pointer, lock/burst, read tag, held bank fields.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_r         <= IW'(NREQ - 1);
      owner_r        <= '0;
      owner_locked_r <= 1'b0;
      burst_cnt_r    <= 8'd0;
      tag_valid_r    <= 1'b0;
      tag_idx_r      <= '0;
      addr_hold_r    <= '0;
      wdata_hold_r   <= '0;
    end else begin
      if (gnt_any_s) begin
        last_r       <= gnt_idx_s;
        addr_hold_r  <= gnt_addr_s;
        wdata_hold_r <= gnt_wdata_s;
      end
      owner_r        <= owner_nxt_s;
      owner_locked_r <= locked_nxt_s;
      burst_cnt_r    <= cnt_nxt_s;
      tag_valid_r    <= gnt_rd_s;
      tag_idx_r      <= gnt_idx_s;
    end
  end
endmodule

// File: tb/tb_spm_bank_arbiter.sv
// Bench for spm_bank_arbiter: table of per-cycle vectors with expected grants,
// a small bank memory model driven by the DUT's bank port, a reference memory
// driven by the stimulus, and a scoreboard of expected read responses.
module tb_spm_bank_arbiter;
  localparam int NREQ = 2;
  localparam int AW   = 9;
  localparam int DW   = 32;
  localparam int MAXB = 4;

  typedef struct packed {
    logic [1:0]  ren;
    logic [1:0]  wen;
    logic [1:0]  lock;
    logic [8:0]  a0;
    logic [8:0]  a1;
    logic [31:0] d0;
    logic [31:0] d1;
    logic [1:0]  gnt;
  } vec_t;

  typedef struct packed {
    logic [1:0]  vld;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  spm_bank_arbiter_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) bus ();
  spm_bank_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .MAX_BURST(MAXB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] mem     [0:511];
  logic [31:0] ref_mem [0:511];
  exp_t        sb  [$];
  vec_t        tbl [$];
  logic        pb_ren, pb_wen;
  logic [8:0]  pb_addr;
  logic [31:0] pb_wdata;

  function automatic vec_t mk(input logic [1:0] ren, input logic [1:0] wen, input logic [1:0] lock,
                              input logic [8:0] a0, input logic [8:0] a1,
                              input logic [31:0] d0, input logic [31:0] d1, input logic [1:0] gnt);
    vec_t v;
    v.ren = ren; v.wen = wen; v.lock = lock; v.a0 = a0; v.a1 = a1;
    v.d0 = d0; v.d1 = d1; v.gnt = gnt;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    end
  endtask

  // One clock cycle: bank answers the previous cycle, inputs applied, outputs checked mid-cycle.
  task automatic cyc(input vec_t v, input logic rst, input logic inject, input string nm);
    exp_t        e;
    int          gi;
    logic        gv, erd, ewr;
    logic [8:0]  ga;
    logic [31:0] gd;
    if (pb_wen) mem[pb_addr] = pb_wdata;
    bus.bank_rvalid = pb_ren | inject;
    bus.bank_rdata  = pb_ren ? mem[pb_addr] : $urandom;
    rst_n         = rst;
    bus.req_ren   = v.ren;
    bus.req_wen   = v.wen;
    bus.req_lock  = v.lock;
    bus.req_addr  = {v.a1, v.a0};
    bus.req_wdata = {v.d1, v.d0};
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    if (!rst) e.vld = 2'b00;
    #4;
    chk({nm, " gnt"}, 32'(bus.req_gnt), 32'(v.gnt));
    chk({nm, " rvalid"}, 32'(bus.req_rvalid), 32'(e.vld));
    if (e.vld != 2'b00) chk({nm, " rdata"}, bus.req_rdata, e.data);
    chk({nm, " orphan"}, 32'(bus.err_orphan), 32'(rst & inject & (e.vld == 2'b00)));
    gv  = (v.gnt != 2'b00);
    gi  = v.gnt[1] ? 1 : 0;
    ga  = (gi == 1) ? v.a1 : v.a0;
    gd  = (gi == 1) ? v.d1 : v.d0;
    erd = gv & v.ren[gi] & ~v.wen[gi];
    ewr = gv & v.wen[gi];
    chk({nm, " bank_ren"}, 32'(bus.bank_ren), 32'(erd));
    chk({nm, " bank_wen"}, 32'(bus.bank_wen), 32'(ewr));
    if (gv)  chk({nm, " bank_addr"}, 32'(bus.bank_addr), 32'(ga));
    if (ewr) chk({nm, " bank_wdata"}, bus.bank_wdata, gd);
    if (erd) sb.push_back({((gi == 1) ? 2'b10 : 2'b01), ref_mem[ga]});
    else     sb.push_back('0);
    if (ewr) ref_mem[ga] = gd;
    pb_ren   = bus.bank_ren;
    pb_wen   = bus.bank_wen;
    pb_addr  = bus.bank_addr;
    pb_wdata = bus.bank_wdata;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t idle;
    idle = mk(2'b00, 2'b00, 2'b00, 9'h000, 9'h000, 32'h0, 32'h0, 2'b00);
    for (int i = 0; i < 512; i++) begin
      mem[i]     = 32'hC0DE0000 | 32'(i);
      ref_mem[i] = 32'hC0DE0000 | 32'(i);
    end
    pb_ren = 1'b0; pb_wen = 1'b0; pb_addr = 9'h000; pb_wdata = 32'h0;
    rst_n = 1'b0;
    bus.req_ren = 2'b11; bus.req_wen = 2'b00; bus.req_lock = 2'b00;
    bus.req_addr = {9'h0AB, 9'h0CD}; bus.req_wdata = {32'h11111111, 32'h22222222};
    bus.bank_rvalid = 1'b0; bus.bank_rdata = 32'h0;
    @(posedge clk);
    @(posedge clk);
    #5;
    chk("rst gnt",        32'(bus.req_gnt),    32'h0);
    chk("rst bank_ren",   32'(bus.bank_ren),   32'h0);
    chk("rst bank_wen",   32'(bus.bank_wen),   32'h0);
    chk("rst bank_addr",  32'(bus.bank_addr),  32'h0);
    chk("rst bank_wdata", bus.bank_wdata,      32'h0);
    chk("rst rvalid",     32'(bus.req_rvalid), 32'h0);
    chk("rst orphan",     32'(bus.err_orphan), 32'h0);
    @(posedge clk);
    #1;
    sb.push_back('0);

    // Round robin, both reading continuously
    tbl.push_back(mk(2'b11, 2'b00, 2'b00, 9'h020, 9'h030, 32'h0, 32'h0, 2'b01));
    tbl.push_back(mk(2'b11, 2'b00, 2'b00, 9'h021, 9'h030, 32'h0, 32'h0, 2'b10));
    tbl.push_back(mk(2'b11, 2'b00, 2'b00, 9'h021, 9'h031, 32'h0, 32'h0, 2'b01));
    tbl.push_back(mk(2'b11, 2'b00, 2'b00, 9'h022, 9'h031, 32'h0, 32'h0, 2'b10));
    tbl.push_back(idle);
    // Locked burst from requester 1 with requester 0 waiting: 1,1,1,1,0,1,1,1,1,0
    tbl.push_back(mk(2'b00, 2'b10, 2'b10, 9'h000, 9'h010, 32'h0, 32'hB0000010, 2'b10));
    tbl.push_back(mk(2'b01, 2'b10, 2'b10, 9'h040, 9'h011, 32'h0, 32'hB0000011, 2'b10));
    tbl.push_back(mk(2'b01, 2'b10, 2'b10, 9'h040, 9'h012, 32'h0, 32'hB0000012, 2'b10));
    tbl.push_back(mk(2'b01, 2'b10, 2'b10, 9'h040, 9'h013, 32'h0, 32'hB0000013, 2'b10));
    tbl.push_back(mk(2'b01, 2'b10, 2'b10, 9'h040, 9'h014, 32'h0, 32'hB0000014, 2'b01));
    tbl.push_back(mk(2'b01, 2'b10, 2'b10, 9'h041, 9'h014, 32'h0, 32'hB0000014, 2'b10));
    tbl.push_back(mk(2'b01, 2'b10, 2'b10, 9'h041, 9'h015, 32'h0, 32'hB0000015, 2'b10));
    tbl.push_back(mk(2'b01, 2'b10, 2'b10, 9'h041, 9'h016, 32'h0, 32'hB0000016, 2'b10));
    tbl.push_back(mk(2'b01, 2'b10, 2'b10, 9'h041, 9'h017, 32'h0, 32'hB0000017, 2'b10));
    tbl.push_back(mk(2'b01, 2'b10, 2'b10, 9'h041, 9'h018, 32'h0, 32'hB0000018, 2'b01));
    tbl.push_back(mk(2'b00, 2'b10, 2'b10, 9'h000, 9'h018, 32'h0, 32'hB0000018, 2'b10));
    tbl.push_back(idle);
    // Requester 0 idle: eight consecutive locked grants, then saturated cap yields
    for (int k = 0; k < 8; k++) begin
      tbl.push_back(mk(2'b00, 2'b10, 2'b10, 9'h000, 9'(16 + k), 32'h0, 32'hC0000010 + 32'(k), 2'b10));
    end
    tbl.push_back(mk(2'b01, 2'b10, 2'b10, 9'h042, 9'h018, 32'h0, 32'hC0000018, 2'b01));
    tbl.push_back(mk(2'b00, 2'b10, 2'b00, 9'h000, 9'h018, 32'h0, 32'hC0000018, 2'b10));
    tbl.push_back(idle);
    // Write then read of the same word
    tbl.push_back(mk(2'b00, 2'b01, 2'b00, 9'h1A0, 9'h000, 32'hDEADBEEF, 32'h0, 2'b01));
    tbl.push_back(mk(2'b10, 2'b00, 2'b00, 9'h000, 9'h1A0, 32'h0, 32'h0, 2'b10));
    tbl.push_back(idle);
    // Both strobes set: treated as a write, no response
    tbl.push_back(mk(2'b01, 2'b01, 2'b00, 9'h005, 9'h000, 32'h12345678, 32'h0, 2'b01));
    tbl.push_back(idle);
    tbl.push_back(mk(2'b01, 2'b00, 2'b00, 9'h005, 9'h000, 32'h0, 32'h0, 2'b01));
    tbl.push_back(mk(2'b01, 2'b00, 2'b00, 9'h013, 9'h000, 32'h0, 32'h0, 2'b01));
    tbl.push_back(idle);

    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i], 1'b1, 1'b0, $sformatf("vec%0d", i));
    end

    // Orphan response: bank answers with nothing pending
    cyc(idle, 1'b1, 1'b1, "orphan");
    cyc(idle, 1'b1, 1'b0, "orphan_end");

    // Reset in the cycle the read response returns, then priority restarts at 0
    cyc(mk(2'b01, 2'b00, 2'b00, 9'h020, 9'h000, 32'h0, 32'h0, 2'b01), 1'b1, 1'b0, "pre_rst");
    cyc(mk(2'b11, 2'b00, 2'b00, 9'h021, 9'h030, 32'h0, 32'h0, 2'b00), 1'b0, 1'b1, "rst_cycle");
    cyc(mk(2'b11, 2'b00, 2'b00, 9'h021, 9'h030, 32'h0, 32'h0, 2'b01), 1'b1, 1'b0, "post_rst");
    cyc(mk(2'b10, 2'b00, 2'b00, 9'h000, 9'h030, 32'h0, 32'h0, 2'b10), 1'b1, 1'b0, "post_rst2");
    cyc(idle, 1'b1, 1'b0, "tail");
    cyc(idle, 1'b1, 1'b0, "tail2");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
